// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the intersection controller and the monitor, plus the
// monitor's fault/status outputs toward the fail-safe and display logic.
interface traffic_light_monitor_if;
  logic [2:0]  light_N;
  logic [2:0]  light_E;
  logic [2:0]  light_S;
  logic [2:0]  light_W;
  logic        fault_clr;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  fault_dir;
  logic        flash;
  logic [15:0] green_cnt;

  // Controller side: drives lamps and clear, observes monitor status.
  modport master (
    output light_N, light_E, light_S, light_W, fault_clr,
    input  fault, fault_code, fault_dir, flash, green_cnt
  );

  // Monitor side.
  modport slave (
    input  light_N, light_E, light_S, light_W, fault_clr,
    output fault, fault_code, fault_dir, flash, green_cnt
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Conflict / sequence / dwell monitor for a four-direction lamp bus.
// Latches the first violation (code + direction), drives a flashing-red
// enable while faulted, and counts red->green onsets.
// Direction index: 0=N, 1=E, 2=S, 3=W.
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 31,
  parameter int FLASH_HALF = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_light_monitor_if.slave   bus
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_ENC   = 3'd1;
  localparam logic [2:0] CODE_CONF  = 3'd2;
  localparam logic [2:0] CODE_TRANS = 3'd3;
  localparam logic [2:0] CODE_SHORT = 3'd4;
  localparam logic [2:0] CODE_STUCK = 3'd5;

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,  // next sample loads the per-direction history
    ST_RUN   = 2'd1,  // full checking
    ST_FAULT = 2'd2   // first fault held, checks frozen
  } state_t;

  state_t state, state_nx;

  // Per-direction history, registered.
  logic [3:0][2:0] prev_p1;
  logic [3:0][7:0] dwell_p1;
  logic [3:0]      partial_p1;

  logic [15:0]     green_cnt_p1;
  logic [2:0]      code_p1;
  logic [1:0]      dir_p1;
  logic            flash_p1;
  logic [FW-1:0]   flash_cnt_p1;

  // Current sample and its evaluation.
  logic [3:0][2:0] lamp_p0;
  logic [3:0][7:0] dwell_nx;
  logic [3:0]      chg;
  logic [3:0]      enc_bad;
  logic [3:0]      nonred;
  logic [3:0]      ill;
  logic [3:0]      shrt;
  logic [3:0]      stuck;
  logic [3:0]      g_edge;
  logic            conflict;
  logic            viol;
  logic            fault_hit;
  logic [2:0]      code_nx;
  logic [1:0]      dir_nx;
  logic [15:0]     g_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
  endfunction

  function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
    return ((from == LAMP_G) && (to == LAMP_Y)) ||
           ((from == LAMP_Y) && (to == LAMP_R)) ||
           ((from == LAMP_R) && (to == LAMP_G));
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] second_idx(input logic [3:0] m);
    logic [1:0] idx;
    logic       seen;
    logic       done;
    idx  = 2'd0;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && !done) begin
        if (seen) begin
          idx  = 2'(i);
          done = 1'b1;
        end else begin
          seen = 1'b1;
        end
      end
    end
    return idx;
  endfunction

  assign lamp_p0 = {bus.light_W, bus.light_S, bus.light_E, bus.light_N};

  // Per-direction checks on the current sample against the stored history.
  always_comb begin
    dwell_nx = '0;
    chg      = '0;
    enc_bad  = '0;
    nonred   = '0;
    ill      = '0;
    shrt     = '0;
    stuck    = '0;
    g_edge   = '0;
    for (int d = 0; d < 4; d++) begin
      dwell_nx[d] = 8'd1;
      enc_bad[d]  = !is_onehot3(lamp_p0[d]);
      nonred[d]   = (lamp_p0[d] == LAMP_Y) || (lamp_p0[d] == LAMP_G);
      if (state == ST_RUN) begin
        chg[d]      = (lamp_p0[d] != prev_p1[d]);
        dwell_nx[d] = chg[d] ? 8'd1 : sat_inc8(dwell_p1[d]);
        if (chg[d]) begin
          ill[d]    = !legal_step(prev_p1[d], lamp_p0[d]);
          // Runs that started before arming have unknown length, so skip them.
          shrt[d]   = !partial_p1[d] &&
                      (((prev_p1[d] == LAMP_G) && (dwell_p1[d] < 8'(MIN_GREEN))) ||
                       ((prev_p1[d] == LAMP_Y) && (dwell_p1[d] < 8'(MIN_YELLOW))));
          g_edge[d] = (prev_p1[d] == LAMP_R) && (lamp_p0[d] == LAMP_G);
        end
        stuck[d] = nonred[d] && (dwell_nx[d] == 8'(MAX_DWELL + 1));
      end
    end
  end

  // Priority fault selection: encoding > conflict > transition > short > stuck.
  always_comb begin
    conflict = (nonred & (nonred - 4'd1)) != 4'd0;
    viol     = 1'b1;
    code_nx  = CODE_NONE;
    dir_nx   = 2'd0;
    if (|enc_bad) begin
      code_nx = CODE_ENC;
      dir_nx  = low_idx(enc_bad);
    end else if (conflict) begin
      code_nx = CODE_CONF;
      dir_nx  = second_idx(nonred);
    end else if (|ill) begin
      code_nx = CODE_TRANS;
      dir_nx  = low_idx(ill);
    end else if (|shrt) begin
      code_nx = CODE_SHORT;
      dir_nx  = low_idx(shrt);
    end else if (|stuck) begin
      code_nx = CODE_STUCK;
      dir_nx  = low_idx(stuck);
    end else begin
      viol = 1'b0;
    end
    fault_hit = viol && (state != ST_FAULT);
    g_inc = 16'(g_edge[0]) + 16'(g_edge[1]) + 16'(g_edge[2]) + 16'(g_edge[3]);
  end

  // Monitor mode register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARM;
    else     state <= state_nx;
  end

  // Mode transitions: arm -> run, any violation -> fault, clear -> re-arm.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ARM:   state_nx = fault_hit ? ST_FAULT : ST_RUN;
      ST_RUN:   if (fault_hit) state_nx = ST_FAULT;
      ST_FAULT: if (bus.fault_clr) state_nx = ST_ARM;
      default:  state_nx = ST_ARM;
    endcase
  end

  // History, counters, latched fault and flash phase. A violating sample is
  // not committed, so the history and green count stay as they were just
  // before the fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p1      <= {4{LAMP_R}};
      dwell_p1     <= '0;
      partial_p1   <= '1;
      green_cnt_p1 <= '0;
      code_p1      <= CODE_NONE;
      dir_p1       <= 2'd0;
      flash_p1     <= 1'b0;
      flash_cnt_p1 <= '0;
    end else begin
      case (state)
        ST_ARM, ST_RUN: begin
          if (fault_hit) begin
            code_p1      <= code_nx;
            dir_p1       <= dir_nx;
            flash_p1     <= 1'b1;
            flash_cnt_p1 <= '0;
          end else if (state == ST_ARM) begin
            prev_p1  <= lamp_p0;
            dwell_p1 <= {4{8'd1}};
          end else begin
            prev_p1      <= lamp_p0;
            dwell_p1     <= dwell_nx;
            partial_p1   <= partial_p1 & ~chg;
            green_cnt_p1 <= green_cnt_p1 + g_inc;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr) begin
            code_p1      <= CODE_NONE;
            dir_p1       <= 2'd0;
            flash_p1     <= 1'b0;
            flash_cnt_p1 <= '0;
            dwell_p1     <= '0;
            partial_p1   <= '1;
          end else if (flash_cnt_p1 == FW'(FLASH_HALF - 1)) begin
            flash_p1     <= ~flash_p1;
            flash_cnt_p1 <= '0;
          end else begin
            flash_cnt_p1 <= flash_cnt_p1 + 1'b1;
          end
        end
        default: begin
          flash_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fault      = (state == ST_FAULT);
  assign bus.fault_code = code_p1;
  assign bus.fault_dir  = dir_p1;
  assign bus.flash      = flash_p1;
  assign bus.green_cnt  = green_cnt_p1;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  traffic_light_monitor_if bus();

  traffic_light_monitor #(
    .MIN_GREEN (4),
    .MIN_YELLOW(2),
    .MAX_DWELL (31),
    .FLASH_HALF(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lamps(input logic [2:0] n, input logic [2:0] e,
                       input logic [2:0] s, input logic [2:0] w);
    bus.light_N = n;
    bus.light_E = e;
    bus.light_S = s;
    bus.light_W = w;
  endtask

  task automatic one(input int d, input logic [2:0] v);
    lamps(R, R, R, R);
    case (d)
      0: bus.light_N = v;
      1: bus.light_E = v;
      2: bus.light_S = v;
      default: bus.light_W = v;
    endcase
  endtask

  task automatic run_round();
    for (int d = 0; d < 4; d++) begin
      one(d, G); tick(11);
      one(d, Y); tick(3);
    end
  endtask

  task automatic clear_and_arm();
    lamps(R, R, R, R);
    bus.fault_clr = 1'b1; tick(1);
    chk("clr_fault", 16'(bus.fault), 16'd0);
    bus.fault_clr = 1'b0; tick(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    lamps(R, R, R, R);
    tick(2);
    chk("rst_fault", 16'(bus.fault), 16'd0);
    chk("rst_code", 16'(bus.fault_code), 16'd0);
    chk("rst_dir", 16'(bus.fault_dir), 16'd0);
    chk("rst_flash", 16'(bus.flash), 16'd0);
    chk("rst_gcnt", bus.green_cnt, 16'd0);
    rst = 1'b0;

    // Arm on all red, then two full rounds of the normal cycle.
    tick(1);
    run_round();
    chk("round1_gcnt", bus.green_cnt, 16'd4);
    run_round();
    lamps(R, R, R, R); tick(1);
    chk("normal_fault", 16'(bus.fault), 16'd0);
    chk("normal_gcnt", bus.green_cnt, 16'd8);

    // Boundary dwells: green exactly 4, then exactly 31.
    one(0, G); tick(4); one(0, Y); tick(2); lamps(R, R, R, R); tick(1);
    chk("green4_fault", 16'(bus.fault), 16'd0);
    one(0, G); tick(31); one(0, Y); tick(2); lamps(R, R, R, R); tick(1);
    chk("green31_fault", 16'(bus.fault), 16'd0);
    chk("green31_gcnt", bus.green_cnt, 16'd10);

    // Stuck: 31 green samples legal, the 32nd faults.
    one(0, G); tick(31);
    chk("stuck_pre", 16'(bus.fault), 16'd0);
    tick(1);
    chk("stuck_fault", 16'(bus.fault), 16'd1);
    chk("stuck_code", 16'(bus.fault_code), 16'd5);
    chk("stuck_dir", 16'(bus.fault_dir), 16'd0);
    chk("stuck_gcnt", bus.green_cnt, 16'd11);
    clear_and_arm();
    chk("clr_code", 16'(bus.fault_code), 16'd0);
    chk("clr_flash", 16'(bus.flash), 16'd0);

    // Conflict: N and E green together.
    lamps(G, G, R, R); tick(1);
    chk("conf_fault", 16'(bus.fault), 16'd1);
    chk("conf_code", 16'(bus.fault_code), 16'd2);
    chk("conf_dir", 16'(bus.fault_dir), 16'd1);
    chk("conf_flash0", 16'(bus.flash), 16'd1);
    lamps(3'b000, G, G, G);
    tick(7);  chk("flash_p7", 16'(bus.flash), 16'd1);
    tick(1);  chk("flash_p8", 16'(bus.flash), 16'd0);
    tick(7);  chk("flash_p15", 16'(bus.flash), 16'd0);
    tick(1);  chk("flash_p16", 16'(bus.flash), 16'd1);
    chk("conf_hold_code", 16'(bus.fault_code), 16'd2);
    chk("conf_hold_gcnt", bus.green_cnt, 16'd11);
    clear_and_arm();

    // Illegal transition: S green 5 then straight to red.
    one(2, G); tick(5);
    one(2, R); tick(1);
    chk("ill_s_code", 16'(bus.fault_code), 16'd3);
    chk("ill_s_dir", 16'(bus.fault_dir), 16'd2);
    chk("ill_s_gcnt", bus.green_cnt, 16'd12);

    // Illegal transition: W yellow (armed on yellow) then green.
    lamps(R, R, R, R);
    bus.fault_clr = 1'b1; tick(1);
    bus.fault_clr = 1'b0;
    one(3, Y); tick(1);
    one(3, G); tick(1);
    chk("ill_w_code", 16'(bus.fault_code), 16'd3);
    chk("ill_w_dir", 16'(bus.fault_dir), 16'd3);
    clear_and_arm();

    // Short green: E green 3 then yellow.
    one(1, G); tick(3);
    one(1, Y); tick(1);
    chk("short_code", 16'(bus.fault_code), 16'd4);
    chk("short_dir", 16'(bus.fault_dir), 16'd1);
    clear_and_arm();

    // Encoding beats conflict.
    lamps(G, G, R, 3'b011); tick(1);
    chk("enc_code", 16'(bus.fault_code), 16'd1);
    chk("enc_dir", 16'(bus.fault_dir), 16'd3);
    chk("enc_gcnt", bus.green_cnt, 16'd13);

    // Clear, then a partial green run (arming on green) leaves after 1 sample.
    lamps(R, R, R, R);
    bus.fault_clr = 1'b1; tick(1);
    chk("clr2_fault", 16'(bus.fault), 16'd0);
    bus.fault_clr = 1'b0;
    one(0, G); tick(1);
    one(0, Y); tick(2);
    lamps(R, R, R, R); tick(1);
    chk("partial_fault", 16'(bus.fault), 16'd0);
    chk("partial_gcnt", bus.green_cnt, 16'd13);

    // Reset mid-fault, while flashing.
    lamps(G, R, Y, R); tick(1);
    chk("conf2_dir", 16'(bus.fault_dir), 16'd2);
    tick(3);
    chk("conf2_flash", 16'(bus.flash), 16'd1);
    rst = 1'b1; tick(1);
    chk("rst2_fault", 16'(bus.fault), 16'd0);
    chk("rst2_code", 16'(bus.fault_code), 16'd0);
    chk("rst2_dir", 16'(bus.fault_dir), 16'd0);
    chk("rst2_flash", 16'(bus.flash), 16'd0);
    chk("rst2_gcnt", bus.green_cnt, 16'd0);
    rst = 1'b0;

    // First sample after reset is N yellow (arming), then N red: legal.
    one(0, Y); tick(1);
    one(0, R); tick(1);
    chk("arm_y_fault", 16'(bus.fault), 16'd0);

    // Fresh flash phase after reset.
    lamps(G, G, R, R); tick(1);
    chk("conf3_flash0", 16'(bus.flash), 16'd1);
    tick(8);
    chk("conf3_flash8", 16'(bus.flash), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
